mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between the instruction-fetch requester and the load/store requester (the `fsm_load_store` datapath) of the multicycle RV64 core. It arbitrates pending requests and latches the winner's address, data and mask. It issues one memory access with a fixed latency and returns read data or write completion to the winner through a req/ack/valid handshake. Only one transaction is in flight at a time.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified memory between the instruction-fetch
// requester and the load/store requester. One transaction is in flight at a
// time: arbitrate in IDLE, strobe the memory in ISSUE, wait MEM_LATENCY
// cycles for read data, then return data/completion in RESP.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between the
// two requesters. Left undefined, load/store has fixed priority over fetch.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access in flight; sample requests, latch winner's operands
// ISSUE   | mem_en strobe, winner's ack pulse, latency counter loaded
// WAIT    | count down the memory latency, capture read data on last cycle
// RESP    | winner's valid pulse; rdata register holds the captured word
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 64,   // multiple of 8
   parameter int MEM_LATENCY = 1     // legal range 1..15
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_ack,
   output logic                    if_valid,
   output logic [DATA_WIDTH-1:0]   if_rdata,

   input  logic                    ls_req,
   input  logic                    ls_write,
   input  logic [ADDR_WIDTH-1:0]   ls_addr,
   input  logic [DATA_WIDTH-1:0]   ls_wdata,
   input  logic [DATA_WIDTH/8-1:0] ls_wmask,
   output logic                    ls_ack,
   output logic                    ls_valid,
   output logic [DATA_WIDTH-1:0]   ls_rdata,

   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wmask,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int          MASK_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0]  LAT_LOAD   = 4'(MEM_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] lat_cnt;
   logic [3:0] lat_cnt_nxt;
   logic       capture;

   // gnt_ls: 1 = load/store owns the current (or most recent) grant, 0 = fetch
   logic       gnt_ls;
   logic       wr_q;
   logic       any_req;
   logic       win_ls;
   logic       take_req;

   assign any_req  = if_req | ls_req;
   assign take_req = (state == ST_IDLE) & any_req;

   // Arbitration decision, evaluated only when a grant is taken in IDLE
   always_comb begin
`ifdef MEM_ARB_RR_EN
      // Both pending: hand the port to whoever did not get the last grant.
      if (if_req && ls_req) begin
         win_ls = ~gnt_ls;
      end else begin
         win_ls = ls_req;
      end
`else
      // Load/store first so the instruction already in progress completes.
      win_ls = ls_req;
`endif
   end

   // State and latency counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         lat_cnt <= 4'd0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
      end
   end

   // Next-state, counter update and read-data capture strobe
   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      capture     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            lat_cnt_nxt = LAT_LOAD;
            state_nxt   = ST_WAIT;
         end
         ST_WAIT: begin
            lat_cnt_nxt = lat_cnt - 4'd1;
            // Count of 1 marks the cycle in which the memory drives rdata.
            if (lat_cnt == 4'd1) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Strobe decode from the registered state and grant
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      if_ack   = 1'b0;
      ls_ack   = 1'b0;
      if_valid = 1'b0;
      ls_valid = 1'b0;
      case (state)
         ST_ISSUE: begin
            mem_en = 1'b1;
            mem_we = wr_q;
            if_ack = ~gnt_ls;
            ls_ack = gnt_ls;
         end
         ST_RESP: begin
            if_valid = ~gnt_ls;
            ls_valid = gnt_ls;
         end
         default: begin
         end
      endcase
   end

   // Grant record and winner's operands, latched when leaving IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_ls    <= 1'b0;
         wr_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else if (take_req) begin
         gnt_ls <= win_ls;
         if (win_ls) begin
            wr_q      <= ls_write;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            // Byte enables are meaningless on a read; keep them at zero.
            mem_wmask <= ls_write ? ls_wmask : {MASK_WIDTH{1'b0}};
         end else begin
            // Fetch carries no write data; mem_wdata keeps its last value.
            wr_q      <= 1'b0;
            mem_addr  <= if_addr;
            mem_wmask <= {MASK_WIDTH{1'b0}};
         end
      end
   end

   // Read data capture into the winner's rdata register; stores leave it alone
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_rdata <= '0;
         ls_rdata <= '0;
      end else if (capture && !wr_q) begin
         if (gnt_ls) begin
            ls_rdata <= mem_rdata;
         end else begin
            if_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: table of single/conflicting requests, a
// reset-in-WAIT sequence, randomized traffic against a transaction-level
// model, and a latency sweep on two extra instances (MEM_LATENCY 1 and 15).
module tb_mem_port_arbiter;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_ack, if_valid;
   logic [63:0] if_rdata;
   logic        ls_req, ls_write;
   logic [63:0] ls_addr, ls_wdata;
   logic [7:0]  ls_wmask;
   logic        ls_ack, ls_valid;
   logic [63:0] ls_rdata;
   logic        mem_en, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_rdata = 64'd0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_valid(if_valid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_ack(ls_ack), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory contents: explicit entries, otherwise a fixed hash of the address
   logic [63:0] mem_img [logic [63:0]];
   function automatic logic [63:0] mem_word(input logic [63:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return {a[31:0] ^ 32'h9E37_79B9, ~a[31:0]};
   endfunction

   // Transaction-level model: one access at a time, timeline in cycle numbers
   int          t_issue = -1, t_valid = -1, free_at = 0;
   logic        sb_ls = 1'b0, sb_wr = 1'b0, last_ls = 1'b0;
   logic [63:0] sb_wdata = '0, sb_rd = '0;
   logic [63:0] exp_if_rdata = '0, exp_ls_rdata = '0, exp_addr = '0;
   logic [7:0]  exp_mask = '0;
   int          n_grants = 0;
   int          mem_cd = 0;
   logic [63:0] mem_pending = '0;
   logic        if_ack_seen = 1'b0, ls_ack_seen = 1'b0;

   always @(negedge clk) begin
      logic [5:0]  exp_str;
      logic        win;
      logic [63:0] w;
      if_ack_seen = if_ack;
      ls_ack_seen = ls_ack;
      if (reset) begin
         chk("rst_strobes", {if_ack, if_valid, ls_ack, ls_valid, mem_en, mem_we}, 64'd0);
         chk("rst_if_rdata", if_rdata, 64'd0);
         chk("rst_ls_rdata", ls_rdata, 64'd0);
         chk("rst_mem_addr", mem_addr, 64'd0);
         chk("rst_mem_wdata", mem_wdata, 64'd0);
         chk("rst_mem_wmask", mem_wmask, 64'd0);
         t_issue = -1; t_valid = -1; free_at = cyc + 1;
         exp_if_rdata = '0; exp_ls_rdata = '0; exp_addr = '0; exp_mask = '0;
         last_ls = 1'b0; mem_cd = 0;
         mem_rdata = {$urandom, $urandom};
      end else begin
         exp_str = {t_issue == cyc && !sb_ls, t_valid == cyc && !sb_ls,
                    t_issue == cyc && sb_ls,  t_valid == cyc && sb_ls,
                    t_issue == cyc,           t_issue == cyc && sb_wr};
         if (t_valid == cyc && !sb_wr) begin
            if (sb_ls) exp_ls_rdata = sb_rd;
            else       exp_if_rdata = sb_rd;
         end
         chk("strobes", {if_ack, if_valid, ls_ack, ls_valid, mem_en, mem_we}, exp_str);
         chk("if_rdata", if_rdata, exp_if_rdata);
         chk("ls_rdata", ls_rdata, exp_ls_rdata);
         chk("mem_addr", mem_addr, exp_addr);
         chk("mem_wmask", mem_wmask, exp_mask);
         if (t_issue == cyc && sb_wr) chk("mem_wdata", mem_wdata, sb_wdata);

         // Memory responder: data is valid only in cycle issue+LAT
         if (mem_cd > 0) begin
            mem_cd--;
            mem_rdata = (mem_cd == 0) ? mem_pending : {$urandom, $urandom};
         end else begin
            mem_rdata = {$urandom, $urandom};
         end
         if (mem_en) begin
            if (mem_we) begin
               w = mem_word(mem_addr);
               for (int b = 0; b < 8; b++)
                  if (mem_wmask[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
               mem_img[mem_addr] = w;
               mem_pending = {$urandom, $urandom};
            end else begin
               mem_pending = mem_word(mem_addr);
            end
            mem_cd = LAT;
         end

         // Arbiter free and someone asking: grant, schedule ack/valid/free
         if (cyc >= free_at && (if_req || ls_req)) begin
`ifdef MEM_ARB_RR_EN
            win = (if_req && ls_req) ? !last_ls : ls_req;
`else
            win = ls_req;
`endif
            last_ls  = win;
            sb_ls    = win;
            sb_wr    = win && ls_write;
            exp_addr = win ? ls_addr : if_addr;
            exp_mask = sb_wr ? ls_wmask : 8'h00;
            sb_wdata = ls_wdata;
            sb_rd    = mem_word(exp_addr);
            t_issue  = cyc + 1;
            t_valid  = cyc + LAT + 2;
            free_at  = cyc + LAT + 3;
            n_grants++;
         end
      end
   end

   // Directed vectors
   typedef struct {
      logic        if_req;
      logic [63:0] if_addr;
      logic        ls_req;
      logic        ls_write;
      logic [63:0] ls_addr;
      logic [63:0] ls_wdata;
      logic [7:0]  ls_wmask;
      logic        first_ls_fixed;
      logic        first_ls_rr;
      logic [63:0] exp_if_rdata;
      logic [63:0] exp_ls_rdata;
   } vec_t;
   vec_t vecs [7];

   task automatic run_vec(input int i);
      vec_t v;
      int a_if, a_ls, v_if, v_ls;
      logic [63:0] first;
      v = vecs[i];
      a_if = -1; a_ls = -1; v_if = -1; v_ls = -1; first = 64'd2;
      @(posedge clk); #1;
      if_req = v.if_req; if_addr = v.if_addr;
      ls_req = v.ls_req; ls_write = v.ls_write; ls_addr = v.ls_addr;
      ls_wdata = v.ls_wdata; ls_wmask = v.ls_wmask;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (if_ack && a_if < 0) begin a_if = cyc; if (first == 2) first = 0; end
         if (ls_ack && a_ls < 0) begin a_ls = cyc; if (first == 2) first = 1; end
         if (if_valid && v_if < 0) v_if = cyc;
         if (ls_valid && v_ls < 0) v_ls = cyc;
         @(posedge clk); #1;
         if (a_if >= 0) if_req = 1'b0;
         if (a_ls >= 0) ls_req = 1'b0;
         if ((!v.if_req || v_if >= 0) && (!v.ls_req || v_ls >= 0)) break;
      end
      if (v.if_req && v.ls_req) begin
`ifdef MEM_ARB_RR_EN
         chk($sformatf("v%0d_first_grant_ls", i), first, {63'd0, v.first_ls_rr});
`else
         chk($sformatf("v%0d_first_grant_ls", i), first, {63'd0, v.first_ls_fixed});
`endif
         chk($sformatf("v%0d_issue_gap", i), 64'(first == 1 ? a_if - a_ls : a_ls - a_if), 64'(LAT + 3));
      end
      if (v.if_req) begin
         chk($sformatf("v%0d_if_latency", i), 64'(v_if - a_if), 64'(LAT + 1));
         chk($sformatf("v%0d_if_rdata", i), if_rdata, v.exp_if_rdata);
      end
      if (v.ls_req)
         chk($sformatf("v%0d_ls_latency", i), 64'(v_ls - a_ls), 64'(LAT + 1));
      chk($sformatf("v%0d_ls_rdata", i), ls_rdata, v.exp_ls_rdata);
   endtask

   task automatic rand_cycle();
      if (if_req) begin
         if (if_ack_seen) begin
            if ($urandom_range(0, 1) == 1) if_addr = 64'($urandom_range(0, 15)) << 3;
            else                           if_req = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            if_req = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         if_req = 1'b1; if_addr = 64'($urandom_range(0, 15)) << 3;
      end
      if (ls_req && !ls_ack_seen) begin
         if ($urandom_range(0, 49) == 0) ls_req = 1'b0;
      end else if ((ls_req && $urandom_range(0, 1) == 1) || (!ls_req && $urandom_range(0, 2) == 0)) begin
         ls_req = 1'b1; ls_write = 1'($urandom_range(0, 1));
         ls_addr = 64'($urandom_range(0, 15)) << 3;
         ls_wdata = {$urandom, $urandom}; ls_wmask = 8'($urandom_range(0, 255));
      end else begin
         ls_req = 1'b0;
      end
   endtask

   // Latency sweep instances: index 0 -> MEM_LATENCY 1, index 1 -> 15
   logic        sw_if_req [2], sw_ls_req [2], sw_ls_write [2];
   logic [63:0] sw_if_addr [2], sw_ls_addr [2], sw_ls_wdata [2];
   logic [7:0]  sw_ls_wmask [2];
   logic        sw_if_ack [2], sw_if_valid [2], sw_ls_ack [2], sw_ls_valid [2];
   logic [63:0] sw_if_rdata [2], sw_ls_rdata [2];
   logic        sw_mem_en [2], sw_mem_we [2];
   logic [63:0] sw_mem_addr [2], sw_mem_wdata [2];
   logic [7:0]  sw_mem_wmask [2];

   for (genvar g = 0; g < 2; g++) begin : g_sw
      localparam int SL = (g == 0) ? 1 : 15;
      logic [63:0] mrd = '0;
      logic [63:0] pend = '0;
      int          cd = 0;
      mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(SL)) u_sw (
         .clk(clk), .reset(reset),
         .if_req(sw_if_req[g]), .if_addr(sw_if_addr[g]), .if_ack(sw_if_ack[g]),
         .if_valid(sw_if_valid[g]), .if_rdata(sw_if_rdata[g]),
         .ls_req(sw_ls_req[g]), .ls_write(sw_ls_write[g]), .ls_addr(sw_ls_addr[g]),
         .ls_wdata(sw_ls_wdata[g]), .ls_wmask(sw_ls_wmask[g]), .ls_ack(sw_ls_ack[g]),
         .ls_valid(sw_ls_valid[g]), .ls_rdata(sw_ls_rdata[g]),
         .mem_en(sw_mem_en[g]), .mem_we(sw_mem_we[g]), .mem_addr(sw_mem_addr[g]),
         .mem_wdata(sw_mem_wdata[g]), .mem_wmask(sw_mem_wmask[g]), .mem_rdata(mrd)
      );
      always @(negedge clk) begin
         if (cd > 0) begin
            cd--;
            mrd = (cd == 0) ? pend : {$urandom, $urandom};
         end else begin
            mrd = {$urandom, $urandom};
         end
         if (sw_mem_en[g]) begin
            pend = sw_mem_addr[g] ^ 64'h0F0F_0000_1234_0000;
            cd   = SL;
         end
      end
   end

   task automatic sweep(input int k, input int lat, input bit use_ls);
      int t_ack, t_val;
      logic [63:0] a;
      t_ack = -1; t_val = -1;
      a = 64'h300 + 64'(k * 16) + (use_ls ? 64'h8 : 64'h0);
      @(posedge clk); #1;
      if (use_ls) begin sw_ls_req[k] = 1'b1; sw_ls_write[k] = 1'b0; sw_ls_addr[k] = a; end
      else        begin sw_if_req[k] = 1'b1; sw_if_addr[k] = a; end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if ((use_ls ? sw_ls_ack[k] : sw_if_ack[k]) && t_ack < 0) t_ack = cyc;
         if ((use_ls ? sw_ls_valid[k] : sw_if_valid[k]) && t_val < 0) t_val = cyc;
         @(posedge clk); #1;
         if (t_ack >= 0) begin sw_if_req[k] = 1'b0; sw_ls_req[k] = 1'b0; end
         if (t_val >= 0) break;
      end
      chk($sformatf("sweep_L%0d_%s_ack_seen", lat, use_ls ? "ls" : "if"), 64'(t_ack >= 0), 64'd1);
      chk($sformatf("sweep_L%0d_%s_latency", lat, use_ls ? "ls" : "if"), 64'(t_val - t_ack), 64'(lat + 1));
      chk($sformatf("sweep_L%0d_%s_rdata", lat, use_ls ? "ls" : "if"),
          use_ls ? sw_ls_rdata[k] : sw_if_rdata[k], a ^ 64'h0F0F_0000_1234_0000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic seen_lsv;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_write = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
      for (int j = 0; j < 2; j++) begin
         sw_if_req[j] = 1'b0; sw_ls_req[j] = 1'b0; sw_ls_write[j] = 1'b0;
         sw_if_addr[j] = '0; sw_ls_addr[j] = '0; sw_ls_wdata[j] = '0; sw_ls_wmask[j] = '0;
      end
      mem_img[64'h40]  = 64'h0000_0000_00A0_0283;
      mem_img[64'h44]  = 64'h0000_0000_00B0_0313;
      mem_img[64'h16]  = 64'h1111_2222_3333_4444;
      mem_img[64'h80]  = 64'h0000_0013_0000_0093;
      mem_img[64'hC0]  = 64'h0000_0000_FFF0_0513;
      mem_img[64'h100] = 64'hCAFE_F00D_1234_5678;
      mem_img[64'h200] = 64'h0;
      //            if  if_addr  ls  wr  ls_addr  ls_wdata                 mask   fix   rr    exp_if_rdata            exp_ls_rdata
      vecs[0] = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0,   64'h0,                 8'h00, 1'b0, 1'b0, 64'h0000_0000_00A0_0283, 64'h0};
      vecs[1] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h16,  64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b0, 1'b0, 64'h0, 64'h0};
      vecs[2] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h16,  64'h0,                 8'h00, 1'b0, 1'b0, 64'h0, 64'h1111_2222_DEAD_BEEF};
      vecs[3] = '{1'b1, 64'h80, 1'b1, 1'b0, 64'h100, 64'h0,                 8'h00, 1'b1, 1'b0, 64'h0000_0013_0000_0093, 64'hCAFE_F00D_1234_5678};
      vecs[4] = '{1'b1, 64'hC0, 1'b0, 1'b0, 64'h0,   64'h0,                 8'h00, 1'b0, 1'b0, 64'h0000_0000_FFF0_0513, 64'hCAFE_F00D_1234_5678};
      vecs[5] = '{1'b1, 64'h44, 1'b1, 1'b1, 64'h200, 64'hA5A5_A5A5_5A5A_5A5A, 8'hF0, 1'b1, 1'b1, 64'h0000_0000_00B0_0313, 64'hCAFE_F00D_1234_5678};
      vecs[6] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h200, 64'h0,                 8'h00, 1'b0, 1'b0, 64'h0, 64'hA5A5_A5A5_0000_0000};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i);

      // Reset during WAIT of a load: abandon it, then a held fetch proceeds
      @(posedge clk); #1;
      ls_req = 1'b1; ls_write = 1'b0; ls_addr = 64'h100;
      k = 0;
      while (k < 10) begin
         @(negedge clk);
         if (ls_ack) break;
         k++;
      end
      chk("rstseq_load_ack", 64'(k < 10), 64'd1);
      @(posedge clk); #1;
      ls_req = 1'b0; if_req = 1'b1; if_addr = 64'h40;
      #2 reset = 1'b1;
      #1;
      chk("rstseq_async_strobes", {if_ack, if_valid, ls_ack, ls_valid, mem_en, mem_we}, 64'd0);
      chk("rstseq_async_ls_rdata", ls_rdata, 64'd0);
      chk("rstseq_async_if_rdata", if_rdata, 64'd0);
      chk("rstseq_async_mem_addr", mem_addr, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      seen_lsv = 1'b0;
      k = 0;
      while (k < 10) begin
         @(negedge clk);
         seen_lsv = seen_lsv | ls_valid;
         if (if_ack) break;
         k++;
      end
      chk("rstseq_fetch_issue_delay", 64'(k), 64'd1);
      @(posedge clk); #1 if_req = 1'b0;
      k = 0;
      while (k < 10) begin
         @(negedge clk);
         seen_lsv = seen_lsv | ls_valid;
         if (if_valid) break;
         k++;
      end
      chk("rstseq_fetch_valid_delay", 64'(k), 64'(LAT));
      chk("rstseq_fetch_rdata", if_rdata, 64'h0000_0000_00A0_0283);
      chk("rstseq_no_ls_valid", 64'(seen_lsv), 64'd0);

      // Randomized traffic, checked cycle by cycle by the model
      n_grants = 0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         rand_cycle();
      end
      @(posedge clk); #1;
      if_req = 1'b0; ls_req = 1'b0;
      repeat (10) @(posedge clk);
      chk("rand_activity", 64'(n_grants > 100), 64'd1);

      sweep(0, 1, 1'b0);
      sweep(0, 1, 1'b1);
      sweep(1, 15, 1'b0);
      sweep(1, 15, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
